// File: rtl/data_mem_resp_if.sv
// Memory-stage load/store request/response bundle between the pipeline (master)
// and the data-memory responder (slave).
interface data_mem_resp_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic                     req_valid;
  logic                     req_we;
  logic [2:0]               req_funct3;
  logic [ADDRESS_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0]    req_wdata;
  logic                     req_ready;
  logic                     stall_m;
  logic                     resp_valid;
  logic [DATA_WIDTH-1:0]    resp_rdata;
  logic                     resp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, stall_m, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, stall_m, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/data_mem_resp.sv
// Data-memory responder: one request at a time, fixed LATENCY, RISC-V byte/half/word
// loads and stores. Define DMEM_MISALIGN_TRAP_EN to trap misaligned accesses instead of aligning down.
module data_mem_resp #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DEPTH_WORDS   = 1024,
  parameter int unsigned LATENCY       = 2
) (
  input logic             clk,
  input logic             rst,
  data_mem_resp_if.slave  mem_if
);
  localparam int unsigned AW = ADDRESS_WIDTH;
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          we_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic [DW-1:0] mem [DEPTH_WORDS];

  logic          idle, a_we, f3_bad, range_bad, acc_err, wr_en;
  logic [2:0]    a_f3;
  logic [AW-1:0] a_addr, a_eff;
  logic [IW-1:0] widx;
  logic [DW-1:0] rd_word, ld_data, wpat;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [3:0]    be;

  // Live inputs describe the request while accepting; captured fields take over afterwards.
  always_comb begin
    idle   = (state_q == IDLE);
    a_we   = idle ? mem_if.req_we     : we_q;
    a_f3   = idle ? mem_if.req_funct3 : f3_q;
    a_addr = idle ? mem_if.req_addr   : addr_q;
    a_eff  = a_addr;
    if (a_f3[1:0] == 2'b01) a_eff[0]   = 1'b0;
    if (a_f3[1:0] == 2'b10) a_eff[1:0] = 2'b00;
    widx = a_eff[IW+1:2];
  end

  always_comb begin
    if (a_we) f3_bad = !(a_f3 inside {3'b000, 3'b001, 3'b010});
    else      f3_bad = !(a_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    range_bad = ({2'b00, a_addr[AW-1:2]} >= AW'(DEPTH_WORDS));
`ifdef DMEM_MISALIGN_TRAP_EN
    acc_err = f3_bad | range_bad
            | ((a_f3[1:0] == 2'b01) & a_addr[0])
            | ((a_f3[1:0] == 2'b10) & (|a_addr[1:0]));
`else
    acc_err = f3_bad | range_bad;
`endif
  end

  always_comb begin
    rd_word = mem[widx];
    rd_byte = rd_word[{a_eff[1:0], 3'b000} +: 8];
    rd_half = rd_word[{a_eff[1], 4'b0000} +: 16];
    case (a_f3)
      3'b000:  ld_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  ld_data = rd_word;
      3'b100:  ld_data = {24'd0, rd_byte};
      3'b101:  ld_data = {16'd0, rd_half};
      default: ld_data = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (mem_if.req_valid) begin
        err_d   = acc_err;
        rdata_d = '0;
        if (acc_err || LATENCY == 1) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
        cnt_d   = '0;
        err_d   = 1'b0;
        rdata_d = '0;
      end
      default: state_d = IDLE;
    endcase
    // The load word is sampled on the edge that enters RESP.
    if (state_d == RESP && state_q != RESP && !err_d && !a_we) rdata_d = ld_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (idle && mem_if.req_valid) begin
        we_q    <= mem_if.req_we;
        f3_q    <= mem_if.req_funct3;
        addr_q  <= mem_if.req_addr;
        wdata_q <= mem_if.req_wdata;
      end
    end
  end

  always_comb begin
    case (f3_q[1:0])
      2'b00:   begin be = 4'b0001 << a_eff[1:0];         wpat = {4{wdata_q[7:0]}};  end
      2'b01:   begin be = 4'b0011 << {a_eff[1], 1'b0};   wpat = {2{wdata_q[15:0]}}; end
      2'b10:   begin be = 4'b1111;                       wpat = wdata_q;            end
      default: begin be = 4'b0000;                       wpat = wdata_q;            end
    endcase
    wr_en = (state_q == RESP) && we_q && !err_q && !rst;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wpat[8*b +: 8];
      end
    end
  end

  assign mem_if.req_ready  = idle;
  assign mem_if.stall_m    = (idle & mem_if.req_valid) | (state_q == WAIT);
  assign mem_if.resp_valid = (state_q == RESP);
  assign mem_if.resp_rdata = mem_if.resp_valid ? rdata_q : '0;
  assign mem_if.resp_err   = mem_if.resp_valid & err_q;
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the 5-stage core: the target end of the memory-stage load/store interface. It accepts one request at a time from the memory stage, applies a configurable access latency, and performs RISC-V byte/half/word stores and sign- or zero-extended loads selected by funct3. It drives a stall back to the hazard logic until the response is returned.

## Interface
- DATA_WIDTH, 32, data bus width; only 32 is supported
- ADDRESS_WIDTH, 32, byte address width
- DEPTH_WORDS, 1024, array depth in 32-bit words
- LATENCY, 2, cycles from request accept to response; legal range is 1..15

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  memory stage presents a load or store
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  access size and signedness
- req_addr  in  ADDRESS_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned
- req_ready  out  1  request accepted this cycle when high together with req_valid
- stall_m  out  1  hold pipeline stages F through M
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores, errors, and whenever resp_valid is low
- resp_err  out  1  request rejected; valid only with resp_valid

## Operation
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state == IDLE).
  - stall_m = (IDLE & req_valid) | WAIT.
  - stall_m is low in RESP so the pipeline advances on the response edge.
- Accept: IDLE & req_valid registers we, funct3, addr, and wdata, then evaluates errors.
  - Error: next state is RESP with resp_err = 1.
  - No error, LATENCY = 1: next state is RESP.
  - No error, LATENCY > 1: next state is WAIT; the counter loads LATENCY-1.
- WAIT decrements the counter and moves to RESP when the counter reaches 1.
- RESP always returns to IDLE. A req_valid that is still high in RESP is never re-accepted.
- Errors (no array access, no write):
  - Load funct3 other than 000 (LB), 001 (LH), 010 (LW), 100 (LBU), 101 (LHU).
  - Store funct3 other than 000 (SB), 001 (SH), 010 (SW).
  - Word index addr[ADDRESS_WIDTH-1:2] >= DEPTH_WORDS.
  - Misalignment, handled according to Configuration.
- Loads:
  - The word is read on the edge entering RESP.
  - The byte lane is selected by addr[1:0]; the half lane by addr[1].
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend.
- Stores:
  - Byte enables come from size and addr[1:0].
  - SB writes req_wdata[7:0] into the selected lane; SH writes [15:0]; SW writes the full word.
  - The write commits on the edge that ends the RESP cycle.
- Array contents are not reset and are not initialised.

## Timing
- Request accepted in cycle N: resp_valid is high in cycle N+LATENCY. An error responds in cycle N+1 regardless of LATENCY.
- Back-to-back requests:
  - Next accept is earliest at cycle N+LATENCY+1, so throughput is one access per LATENCY+1 cycles.
  - A load accepted after a store to the same word returns the stored data.
- State after reset: IDLE, counter 0, resp_valid = 0, resp_rdata = 0, resp_err = 0, req_ready = 1, stall_m = req_valid.
- Reset mid-operation (WAIT or RESP):
  - The FSM returns to IDLE the next cycle with no response.
  - A pending store does not commit; if rst is asserted in the RESP cycle, the write is suppressed.
- Registered request fields are ignored in IDLE; input changes during WAIT have no effect.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - Half access with addr[0] = 1, or word access with addr[1:0] != 0, gives resp_err = 1.
  - The store is dropped; rdata is 0.
- DMEM_MISALIGN_TRAP_EN undefined:
  - Misaligned addresses are silently aligned down (half: addr[0] forced to 0; word: addr[1:0] forced to 00).
  - The access completes normally; funct3 and range errors are unaffected.

## Test plan
- LATENCY = 2: SW addr 0x10 data 0xDEADBEEF accepted in cycle N -> resp_valid in N+2 with rdata 0 and err 0; then LW 0x10 -> rdata 0xDEADBEEF in its N+2.
- After the above: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x10 -> 0xFFFFBEEF; LHU 0x12 -> 0x0000DEAD.
- SB 0x11 data 0x12 over 0xDEADBEEF -> LW 0x10 returns 0xDEAD12EF; SH 0x12 data 0xAAAA -> LW returns 0xAAAA12EF.
- Errors: LW addr 0x1000 (DEPTH 1024) -> resp_err in cycle N+1, rdata 0; load funct3 011 -> err; store funct3 100 -> err; memory unchanged after each.
- LH 0x11:
  - With DMEM_MISALIGN_TRAP_EN -> err.
  - Without it -> returns the half at 0x10.
- Mid-operation reset and stall:
  - SW 0x20 data 0x5 with rst pulsed in cycle N+1 -> no resp_valid, FSM back in IDLE; a later LW 0x20 does not return 0x5.
  - stall_m is high in cycles N and N+1 and low in N+2.
